// File: rtl/hex_scan_ctrl.sv
// Drives four 7-segment digits from a single shared hex decoder, scanning one digit at a time.
// Build option: define HEX_LZB_EN to blank leading zeros (hex0 is never blanked).
module hex_scan_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] value,
    output logic [3:0]  dec_in,
    input  logic [6:0]  dec_out,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic        busy,
    output logic        done
);

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_LATCH,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [15:0]     val_q, val_d;
    logic [3:0][6:0] hex_q, hex_d;
    logic [3:0]      nib;
    logic            blank;

    assign nib = val_q[{idx_q, 2'b00} +: 4];

`ifdef HEX_LZB_EN
    // Stays set while every nibble scanned so far in this pass has been zero.
    logic zf_q, zf_d;

    always_comb begin
        zf_d = zf_q;
        if (state_q == S_IDLE && load) begin
            zf_d = 1'b1;
        end else if (state_q == S_LATCH) begin
            zf_d = zf_q & (nib == 4'h0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            zf_q <= 1'b1;
        end else begin
            zf_q <= zf_d;
        end
    end

    assign blank = zf_q && (nib == 4'h0) && (idx_q != 2'd0);
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        val_d   = val_q;
        hex_d   = hex_q;
        dec_in  = 4'h0;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (load) begin
                    val_d   = value;
                    idx_d   = 2'd3;
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                dec_in  = nib;
                state_d = S_LATCH;
            end
            S_LATCH: begin
                dec_in        = nib;
                hex_d[idx_q]  = blank ? SEG_BLANK : dec_out;
                if (idx_q != 2'd0) begin
                    idx_d   = idx_q - 2'd1;
                    state_d = S_DRIVE;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd3;
            val_q   <= 16'h0000;
            hex_q   <= {4{SEG_BLANK}};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            val_q   <= val_d;
            hex_q   <= hex_d;
        end
    end

    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Self-checking bench for hex_scan_ctrl with a behavioural 4-bit hex decoder on dec_in/dec_out.
module tb_hex_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dec_in;
    logic [6:0]  dec_out;
    logic [6:0]  hex0, hex1, hex2, hex3;
    logic        busy, done;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [6:0] BL = 7'h7F;

    always #5 clk = ~clk;

    hex_scan_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .value   (value),
        .dec_in  (dec_in),
        .dec_out (dec_out),
        .hex0    (hex0),
        .hex1    (hex1),
        .hex2    (hex2),
        .hex3    (hex3),
        .busy    (busy),
        .done    (done)
    );

    // Active-low segments, bit 6 = g ... bit 0 = a.
    always_comb begin
        dec_out = 7'h7F;
        case (dec_in)
            4'h0: dec_out = 7'b1000000;
            4'h1: dec_out = 7'b1111001;
            4'h2: dec_out = 7'b0100100;
            4'h3: dec_out = 7'b0110000;
            4'h4: dec_out = 7'b0011001;
            4'h5: dec_out = 7'b0010010;
            4'h6: dec_out = 7'b0000010;
            4'h7: dec_out = 7'b1111000;
            4'h8: dec_out = 7'b0000000;
            4'h9: dec_out = 7'b0010000;
            4'hA: dec_out = 7'b0001000;
            4'hB: dec_out = 7'b0000011;
            4'hC: dec_out = 7'b1000110;
            4'hD: dec_out = 7'b0100001;
            4'hE: dec_out = 7'b0000110;
            4'hF: dec_out = 7'b0001110;
            default: dec_out = 7'h7F;
        endcase
    end

    typedef struct {
        logic [15:0] v;
        logic [6:0]  e3, e2, e1, e0;
        string       name;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_hex(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                           input logic [6:0] e1, input logic [6:0] e0);
        chk({tag, ".hex3"}, {25'd0, hex3}, {25'd0, e3});
        chk({tag, ".hex2"}, {25'd0, hex2}, {25'd0, e2});
        chk({tag, ".hex1"}, {25'd0, hex1}, {25'd0, e1});
        chk({tag, ".hex0"}, {25'd0, hex0}, {25'd0, e0});
    endtask

    // One-cycle load pulse, then cycle-by-cycle check of busy/done/dec_in; value is scrambled mid-scan.
    task automatic scan(input logic [15:0] v, input logic [6:0] e3, input logic [6:0] e2,
                        input logic [6:0] e1, input logic [6:0] e0, input string tag);
        int d;
        logic [3:0] nib;
        @(negedge clk);
        load  = 1'b1;
        value = v;
        @(negedge clk);
        load  = 1'b0;
        value = ~v;
        for (int j = 1; j <= 10; j++) begin
            chk({tag, ".busy"}, {31'd0, busy}, {31'd0, (j <= 9)});
            chk({tag, ".done"}, {31'd0, done}, {31'd0, (j == 9)});
            if (j <= 8) begin
                d   = 3 - (j - 1) / 2;
                nib = v[d*4 +: 4];
            end else begin
                nib = 4'h0;
            end
            chk({tag, ".dec_in"}, {28'd0, dec_in}, {28'd0, nib});
            if (j == 3) chk({tag, ".hex3_early"}, {25'd0, hex3}, {25'd0, e3});
            if (j < 10) @(negedge clk);
        end
        chk_hex(tag, e3, e2, e1, e0);
    endtask

    initial begin
        vecs[0] = '{16'h1234, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, "v1234"};
        vecs[1] = '{16'h9C0E, 7'b0010000, 7'b1000110, 7'b1000000, 7'b0000110, "v9C0E"};
`ifdef HEX_LZB_EN
        vecs[2] = '{16'h00A5, BL,         BL,         7'b0001000, 7'b0010010, "v00A5"};
        vecs[3] = '{16'h0000, BL,         BL,         BL,         7'b1000000, "v0000"};
        vecs[4] = '{16'h0F00, BL,         7'b0001110, 7'b1000000, 7'b1000000, "v0F00"};
        vecs[5] = '{16'h0B0D, BL,         7'b0000011, 7'b1000000, 7'b0100001, "v0B0D"};
`else
        vecs[2] = '{16'h00A5, 7'b1000000, 7'b1000000, 7'b0001000, 7'b0010010, "v00A5"};
        vecs[3] = '{16'h0000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, "v0000"};
        vecs[4] = '{16'h0F00, 7'b1000000, 7'b0001110, 7'b1000000, 7'b1000000, "v0F00"};
        vecs[5] = '{16'h0B0D, 7'b1000000, 7'b0000011, 7'b1000000, 7'b0100001, "v0B0D"};
`endif
        vecs[6] = '{16'hFEDC, 7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110, "vFEDC"};

        reset = 1'b1;
        load  = 1'b0;
        value = 16'h0000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk_hex("rst", BL, BL, BL, BL);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.done", {31'd0, done}, 32'd0);
        chk("rst.dec_in", {28'd0, dec_in}, 32'd0);

        for (int i = 0; i < 7; i++) begin
            scan(vecs[i].v, vecs[i].e3, vecs[i].e2, vecs[i].e1, vecs[i].e0, vecs[i].name);
        end

        // Load during scan is ignored.
        @(negedge clk);
        load = 1'b1;
        value = 16'hFFFF;
        @(negedge clk);
        load = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            if (j == 4) begin
                load  = 1'b1;
                value = 16'h0000;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
        chk("ign.busy", {31'd0, busy}, 32'd0);
        chk_hex("ign", 7'b0001110, 7'b0001110, 7'b0001110, 7'b0001110);

        // Mid-scan reset, then a normal scan.
        @(negedge clk);
        load = 1'b1;
        value = 16'h8888;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_hex("midrst", BL, BL, BL, BL);
        chk("midrst.busy", {31'd0, busy}, 32'd0);
        chk("midrst.done", {31'd0, done}, 32'd0);
        chk("midrst.dec_in", {28'd0, dec_in}, 32'd0);
`ifdef HEX_LZB_EN
        scan(16'h0007, BL, BL, BL, 7'b1111000, "v0007");
`else
        scan(16'h0007, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1111000, "v0007");
`endif

        // Load coincident with reset is dropped; first load after release is taken at once.
        @(negedge clk);
        reset = 1'b1;
        load  = 1'b1;
        value = 16'h1234;
        @(negedge clk);
        reset = 1'b0;
        load  = 1'b0;
        chk("rstload.busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("rstload.busy2", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        chk("firstload.busy", {31'd0, busy}, 32'd1);
        repeat (9) @(negedge clk);
        chk_hex("firstload", 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001);

        // Load held high: a new scan starts every 10 cycles.
        @(negedge clk);
        load  = 1'b1;
        value = 16'h1234;
        @(negedge clk);
        for (int j = 1; j <= 20; j++) begin
            chk("b2b.busy", {31'd0, busy}, {31'd0, (j % 10 != 0)});
            chk("b2b.done", {31'd0, done}, {31'd0, (j % 10 == 9)});
            @(negedge clk);
        end
        load = 1'b0;
        repeat (10) @(negedge clk);
        chk("b2b.idle", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
